// File: rtl/branch_target_predictor.sv
// Branch target predictor for the RISC-V pipeline.
// IF side: direct-mapped BTB with 2-bit saturating counters gives a
// taken/not-taken prediction and next PC for the fetch PC with no latency.
// EX side: resolves the real outcome, flags a mispredict with the correct
// redirect PC, trains the table on the clock edge and keeps statistics.
module branch_target_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        UpdateValidE,
    input  logic [2:0]  BranchTypeE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 32 - IDXW - 2;

    // Table storage, one slot per index.
    logic              valid_q  [ENTRIES];
    logic [TAGW-1:0]   tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    // Fetch-side lookup fields.
    logic [IDXW-1:0]   idx_f;
    logic [TAGW-1:0]   tag_f;
    logic              hit_f;

    // EX-side lookup fields.
    logic [IDXW-1:0]   idx_e;
    logic [TAGW-1:0]   tag_e;
    logic              hit_e;

    // Update handshake: the EX stage offers a training/resolve transaction
    // by holding UpdateValidE high with a nonzero BranchTypeE for exactly one
    // cycle; there is no back-pressure (the predictor always accepts), so the
    // transaction completes on the rising edge that ends that cycle. Reset
    // low suppresses the transaction entirely.
    logic              upd;

    assign idx_f = PCF[IDXW+1:2];
    assign tag_f = PCF[31:IDXW+2];
    assign idx_e = PCE[IDXW+1:2];
    assign tag_e = PCE[31:IDXW+2];
    assign upd   = rst_n & UpdateValidE & (BranchTypeE != 3'b000);

    // Zero-latency prediction from the registered table (no bypass of a
    // same-cycle update).
    always_comb begin
        hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        PredTakenF  = 1'b0;
        PredTargetF = PCF + 32'd4;
        if (hit_f && ctr_q[idx_f][1]) begin
            PredTakenF  = 1'b1;
            PredTargetF = target_q[idx_f];
        end
    end

    // Outcome resolution: mispredict on wrong direction, or right direction
    // (taken) with the wrong target.
    always_comb begin
        hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        MispredictE = upd & ((BranchE != PredTakenE) |
                             (BranchE & PredTakenE & (PredTargetE != BrTargetE)));
        RedirectPCE = BranchE ? BrTargetE : (PCE + 32'd4);
    end

    // Table training and statistics; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            BranchCount  <= '0;
            MispredCount <= '0;
        end else if (upd) begin
            BranchCount <= BranchCount + 32'd1;
            if (MispredictE) begin
                MispredCount <= MispredCount + 32'd1;
            end
            if (hit_e) begin
                if (BranchE) begin
                    if (ctr_q[idx_e] != 2'b11) begin
                        ctr_q[idx_e] <= ctr_q[idx_e] + 2'b01;
                    end
                    target_q[idx_e] <= BrTargetE;
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_q[idx_e] <= ctr_q[idx_e] - 2'b01;
                end
            end else if (BranchE) begin
                // Taken miss allocates (or replaces an aliasing entry) weak-taken.
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= BrTargetE;
                ctr_q[idx_e]    <= 2'b10;
            end
        end
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-stage branch predictor and EX-stage outcome resolver for the RISC-V pipeline. In IF it predicts taken/not-taken and a target for the fetch PC. In EX it consumes the resolved branch outcome from the branch comparator, trains the table and flags a mispredict with the correct redirect PC. Direct-mapped branch target buffer with 2-bit saturating counters, plus free-running branch and mispredict statistic counters.

## Interface
Parameters:
- ENTRIES, 16, number of table entries (power of two, 4–64); IDXW = log2(ENTRIES)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- PCF  in  32  fetch PC
- PredTakenF  out  1  predicted taken for PCF
- PredTargetF  out  32  predicted next PC for PCF
- UpdateValidE  in  1  instruction in EX is valid (not flushed, not stalled)
- BranchTypeE  in  3  branch type in EX; 3'b000 = no branch, any nonzero = conditional branch
- PCE  in  32  PC of instruction in EX
- BranchE  in  1  resolved outcome from the branch comparator, 1 = taken
- BrTargetE  in  32  computed branch target
- PredTakenE, PredTargetE  in  1/32  prediction carried down the pipeline with the instruction
- MispredictE  out  1  prediction wrong, flush IF/ID and redirect
- RedirectPCE  out  32  correct next PC
- BranchCount, MispredCount  out  32  statistics

## Operation
- Per entry: valid (1), tag (32-IDXW-2), target (32), ctr (2). ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Index = PC[IDXW+1:2], tag = PC[31:IDXW+2]; PC[1:0] ignored.
- Predict (combinational from registered table): hit = valid & tag match. If hit & ctr[1]: PredTakenF=1, PredTargetF=target. Otherwise PredTakenF=0, PredTargetF=PCF+4 (modulo 2^32).
- Resolve (combinational), active when upd = UpdateValidE & (BranchTypeE != 0):
  - MispredictE = upd & ((BranchE != PredTakenE) | (BranchE & PredTakenE & (PredTargetE != BrTargetE))).
  - RedirectPCE = BranchE ? BrTargetE : PCE+4. It is driven regardless of upd; consumers qualify it with MispredictE.
  - MispredictE=0 whenever upd=0.
- Train (rising edge, when upd=1), indexed by PCE:
  - Hit, taken: ctr saturating increment (11 stays 11); target ← BrTargetE.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace entry with valid=1, tag, target=BrTargetE, ctr=10.
  - Miss, not taken: no change.
- Statistics: BranchCount +1 per upd cycle. MispredCount +1 per cycle with MispredictE=1. Both wrap at 2^32.

## Timing
- Prediction latency: 0 cycles (same cycle as PCF). Training becomes visible to prediction on the cycle after the update edge.
- Same-cycle predict and train of the same index: the prediction uses the pre-update contents; there is no bypass.
- MispredictE and RedirectPCE are valid in the same cycle as the EX inputs.
- Reset (async assert, any time, including mid-update): all valid=0, ctr=01, tag/target=0, both counters=0.
  - While rst_n=0: PredTakenF=0, PredTargetF=PCF+4, MispredictE=0.
  - First edge after release samples normally.
- UpdateValidE=0 (stall/flush): no table or counter change.
- Aliasing between PCs with the same index and different tag: a taken branch replaces the entry; a not-taken branch leaves it.

## Test plan
- Reset, then PCF=0x100 → PredTakenF=0, PredTargetF=0x104. Both counters read 0.
- EX taken branch PCE=0x100, BrTargetE=0x80, PredTakenE=0 → MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 → PredTakenF=1, PredTargetF=0x80. MispredCount=1, BranchCount=1.
- Same branch resolves not-taken twice (PredTakenE=1, then 0) → first update MispredictE=1, RedirectPCE=0x104, ctr 10→01. Second update MispredictE=0, ctr→00. Prediction for 0x100 is not-taken afterwards.
- Alias with ENTRIES=16: 0x100 allocated, then taken branch at 0x140 (same index) → 0x100 misses and predicts 0x104; 0x140 predicts its target. A not-taken branch at 0x180 leaves the entry unchanged.
- Predicted taken, target wrong: PredTargetE=0x80, BrTargetE=0x90, BranchE=1 → MispredictE=1, RedirectPCE=0x90, entry target updated to 0x90.
- BranchTypeE=0 or UpdateValidE=0 with BranchE=1 → MispredictE=0, no counter or table change. Assert rst_n low mid-run → all outputs return to their reset values asynchronously.
